// File: rtl/regfile_write_scheduler_if.sv
// Write-port scheduler bundle: pipeline writeback, long-latency result, issue and decode taps, regfile port.
// master = core side driving requests, slave = the scheduler.
interface regfile_write_scheduler_if #(
  parameter int DATA_W = 32
);
  logic              wb_we;
  logic [4:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              lu_valid;
  logic              lu_ready;
  logic [4:0]        lu_addr;
  logic [DATA_W-1:0] lu_data;
  logic              issue_valid;
  logic [4:0]        issue_dst;
  logic [4:0]        rs_addr;
  logic [4:0]        rt_addr;
  logic [4:0]        rd_addr;
  logic              WE3;
  logic [4:0]        A3;
  logic [DATA_W-1:0] WD3;
  logic              stall;
  logic [31:0]       pending;

  modport master (
    output wb_we, wb_addr, wb_data, lu_valid, lu_addr, lu_data,
           issue_valid, issue_dst, rs_addr, rt_addr, rd_addr,
    input  lu_ready, WE3, A3, WD3, stall, pending
  );

  modport slave (
    input  wb_we, wb_addr, wb_data, lu_valid, lu_addr, lu_data,
           issue_valid, issue_dst, rs_addr, rt_addr, rd_addr,
    output lu_ready, WE3, A3, WD3, stall, pending
  );
endinterface

// File: rtl/regfile_write_scheduler.sv
// Shares the regfile write port between pipeline writeback (priority) and a FIFO of long-latency results,
// tracks pending long-latency destinations and drives a registered decode stall. Macro: REGFILE_SCHED_BYPASS_EN.
module regfile_write_scheduler #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  regfile_write_scheduler_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [4:0]        addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WB   = 2'b01,
    S_LU   = 2'b10
  } state_t;

  entry_t            mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              lu_ready_q;
  logic [31:0]       pending_q, pending_d;
  logic [31:0]       pend_set, pend_clr;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic              stall_q, stall_d;
  state_t            state_q, state_d;
  logic [4:0]        a3_q, a3_d;
  logic [DATA_W-1:0] wd3_q, wd3_d;

  logic   fifo_empty, fifo_full;
  logic   lu_acc, bypass, push, pop, lu_gnt;
  logic   starve_sat;
  entry_t head, lu_in, gnt;

  always_comb begin
    fifo_empty = (cnt_q == '0);
    fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH));
    lu_acc     = bus.lu_valid & lu_ready_q;
`ifdef REGFILE_SCHED_BYPASS_EN
    bypass     = lu_acc & fifo_empty & ~bus.wb_we;
`else
    bypass     = 1'b0;
`endif
    push       = lu_acc & ~bypass;
    pop        = ~fifo_empty & ~bus.wb_we;
    lu_gnt     = pop | bypass;
    head       = mem_q[rd_ptr_q];
    lu_in      = '{addr: bus.lu_addr, data: bus.lu_data};
    gnt        = pop ? head : lu_in;
    cnt_d      = cnt_q + CNT_W'(push) - CNT_W'(pop);
    starve_sat = (starve_q == STV_W'(STARVE_MAX));
  end

  // Grant decision: pipeline first, then FIFO head (or bypassed result); register 0 writes are swallowed.
  always_comb begin
    state_d = S_IDLE;
    a3_d    = a3_q;
    wd3_d   = wd3_q;
    if (bus.wb_we) begin
      if (bus.wb_addr != 5'd0) begin
        state_d = S_WB;
        a3_d    = bus.wb_addr;
        wd3_d   = bus.wb_data;
      end
    end else if (lu_gnt) begin
      if (gnt.addr != 5'd0) begin
        state_d = S_LU;
        a3_d    = gnt.addr;
        wd3_d   = gnt.data;
      end
    end
  end

  always_comb begin
    pend_clr  = lu_gnt ? (32'd1 << gnt.addr) : 32'd0;
    pend_set  = (bus.issue_valid && bus.issue_dst != 5'd0) ? (32'd1 << bus.issue_dst) : 32'd0;
    // A new issue to a register whose result is landing now is a fresh dependency, so set beats clear.
    pending_d = (pending_q & ~pend_clr) | pend_set;

    starve_d = '0;
    if (!fifo_empty && bus.wb_we) begin
      starve_d = starve_sat ? starve_q : starve_q + STV_W'(1);
    end

    stall_d = (pending_q[bus.rs_addr] && bus.rs_addr != 5'd0)
            | (pending_q[bus.rt_addr] && bus.rt_addr != 5'd0)
            | (pending_q[bus.rd_addr] && bus.rd_addr != 5'd0)
            | starve_sat
            | (fifo_full & bus.lu_valid);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      a3_q    <= '0;
      wd3_q   <= '0;
    end else begin
      state_q <= state_d;
      a3_q    <= a3_d;
      wd3_q   <= wd3_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      lu_ready_q <= 1'b0;
      pending_q  <= '0;
      starve_q   <= '0;
      stall_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q      <= cnt_d;
      lu_ready_q <= (cnt_d != CNT_W'(FIFO_DEPTH));
      pending_q  <= pending_d;
      starve_q   <= starve_d;
      stall_q    <= stall_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by cnt_q alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= lu_in;
  end

  assign bus.WE3      = (state_q != S_IDLE);
  assign bus.A3       = a3_q;
  assign bus.WD3      = wd3_q;
  assign bus.stall    = stall_q;
  assign bus.pending  = pending_q;
  assign bus.lu_ready = lu_ready_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Bench for regfile_write_scheduler: directed vector table, async-reset sequence, and random traffic
// against a queue-based reference model.
module tb_regfile_write_scheduler;

  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 2;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  regfile_write_scheduler_if #(.DATA_W(DATA_W)) bus ();

  regfile_write_scheduler #(
    .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: result queue, pending bitmap, starve count, expected outputs.
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pend;
  int          m_starve;
  logic        m_we, m_rdy, m_stall;
  logic [4:0]  m_a3;
  logic [31:0] m_wd3;
  bit          chk_model = 0;

  task automatic model_reset();
    mq.delete();
    m_pend = 0; m_starve = 0;
    m_we = 0; m_rdy = 0; m_stall = 0; m_a3 = 0; m_wd3 = 0;
  endtask

  task automatic model_edge();
    bit   empty, full, acc, byp, nstall;
    ent_t h;
    empty  = (mq.size() == 0);
    full   = (mq.size() == FIFO_DEPTH);
    acc    = bus.lu_valid && m_rdy;
    nstall = m_pend[bus.rs_addr] || m_pend[bus.rt_addr] || m_pend[bus.rd_addr]
             || (m_starve == STARVE_MAX) || (full && bus.lu_valid);
    byp = 0;
`ifdef REGFILE_SCHED_BYPASS_EN
    byp = acc && empty && !bus.wb_we;
`endif
    m_we = 0;
    if (bus.wb_we) begin
      if (bus.wb_addr != 0) begin m_we = 1; m_a3 = bus.wb_addr; m_wd3 = bus.wb_data; end
      m_starve = empty ? 0 : ((m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1);
    end else if (!empty) begin
      h = mq.pop_front();
      m_pend[h.a] = 0;
      if (h.a != 0) begin m_we = 1; m_a3 = h.a; m_wd3 = h.d; end
      m_starve = 0;
    end else begin
      m_starve = 0;
      if (byp) begin
        m_pend[bus.lu_addr] = 0;
        if (bus.lu_addr != 0) begin m_we = 1; m_a3 = bus.lu_addr; m_wd3 = bus.lu_data; end
      end
    end
    if (acc && !byp) mq.push_back('{a: bus.lu_addr, d: bus.lu_data});
    if (bus.issue_valid && bus.issue_dst != 0) m_pend[bus.issue_dst] = 1;
    m_rdy   = (mq.size() < FIFO_DEPTH);
    m_stall = nstall;
  endtask

  task automatic check_model();
    chk("m_WE3", {31'd0, bus.WE3}, {31'd0, m_we});
    chk("m_A3", {27'd0, bus.A3}, {27'd0, m_a3});
    chk("m_WD3", bus.WD3, m_wd3);
    chk("m_stall", {31'd0, bus.stall}, {31'd0, m_stall});
    chk("m_pending", bus.pending, m_pend);
    chk("m_lu_ready", {31'd0, bus.lu_ready}, {31'd0, m_rdy});
  endtask

  // Called just after a negedge: apply current inputs at the next posedge, observe at the following negedge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (chk_model) check_model();
  endtask

  task automatic idle_inputs();
    bus.wb_we = 0; bus.wb_addr = 0; bus.wb_data = 0;
    bus.lu_valid = 0; bus.lu_addr = 0; bus.lu_data = 0;
    bus.issue_valid = 0; bus.issue_dst = 0;
    bus.rs_addr = 0; bus.rt_addr = 0; bus.rd_addr = 0;
  endtask

  task automatic do_reset();
    #2 reset = 0;
    model_reset();
    @(negedge clk);
    reset = 1;
  endtask

  typedef struct {
    logic        wb_we;   logic [4:0] wb_addr; logic [31:0] wb_data;
    logic        lu_valid; logic [4:0] lu_addr; logic [31:0] lu_data;
    logic        iv;      logic [4:0] idst;
    logic [4:0]  rs, rt, rd;
    logic        e_we;    logic [4:0] e_a3;   logic [31:0] e_wd3;
    logic        e_stall; logic [31:0] e_pend; logic e_rdy;
  } vec_t;

  function automatic vec_t v(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                             input logic l, input logic [4:0] la, input logic [31:0] ld,
                             input logic iv, input logic [4:0] id,
                             input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                             input logic ewe, input logic [4:0] ea, input logic [31:0] ed,
                             input logic es, input logic [31:0] ep, input logic er);
    v = '{w, wa, wd, l, la, ld, iv, id, rs, rt, rd, ewe, ea, ed, es, ep, er};
  endfunction

  vec_t tbl[$];

  initial begin
    idle_inputs();
    model_reset();
    // Vectors run back-to-back from reset; expectations are the outputs after each posedge.
    tbl.push_back(v(0,0,0,           0,0,0,           0,0, 0,0,0, 0,0,32'h0,        0,32'h0,  1));
    tbl.push_back(v(1,5,32'hDEADBEEF,0,0,0,           0,0, 0,0,0, 1,5,32'hDEADBEEF, 0,32'h0,  1));
    tbl.push_back(v(1,0,32'h11111111,0,0,0,           0,0, 0,0,0, 0,5,32'hDEADBEEF, 0,32'h0,  1));
    tbl.push_back(v(0,0,0,           0,0,0,           1,9, 0,0,0, 0,5,32'hDEADBEEF, 0,32'h200,1));
    tbl.push_back(v(0,0,0,           0,0,0,           0,0, 9,0,0, 0,5,32'hDEADBEEF, 1,32'h200,1));
    tbl.push_back(v(0,0,0,           1,9,32'h1234,    0,0, 9,0,0, 0,5,32'hDEADBEEF, 1,32'h200,1));
    tbl.push_back(v(0,0,0,           0,0,0,           0,0, 9,0,0, 1,9,32'h1234,     1,32'h0,  1));
    tbl.push_back(v(0,0,0,           0,0,0,           0,0, 9,0,0, 0,9,32'h1234,     0,32'h0,  1));
    tbl.push_back(v(1,4,32'h44,      1,3,32'hAAAA0003,0,0, 0,0,0, 1,4,32'h44,       0,32'h0,  1));
    tbl.push_back(v(1,4,32'h45,      0,0,0,           0,0, 0,0,0, 1,4,32'h45,       0,32'h0,  1));
    tbl.push_back(v(1,4,32'h46,      0,0,0,           0,0, 0,0,0, 1,4,32'h46,       0,32'h0,  1));
    tbl.push_back(v(1,4,32'h47,      0,0,0,           0,0, 0,0,0, 1,4,32'h47,       0,32'h0,  1));
    tbl.push_back(v(1,4,32'h48,      0,0,0,           0,0, 0,0,0, 1,4,32'h48,       0,32'h0,  1));
    tbl.push_back(v(1,4,32'h49,      0,0,0,           0,0, 0,0,0, 1,4,32'h49,       1,32'h0,  1));
    tbl.push_back(v(0,0,0,           0,0,0,           0,0, 0,0,0, 1,3,32'hAAAA0003, 1,32'h0,  1));
    tbl.push_back(v(0,0,0,           0,0,0,           0,0, 0,0,0, 0,3,32'hAAAA0003, 0,32'h0,  1));
    tbl.push_back(v(1,6,32'h60,      1,10,32'hA0,     0,0, 0,0,0, 1,6,32'h60,       0,32'h0,  1));
    tbl.push_back(v(1,6,32'h61,      1,11,32'hB0,     0,0, 0,0,0, 1,6,32'h61,       0,32'h0,  0));
    tbl.push_back(v(1,6,32'h62,      1,12,32'hC0,     0,0, 0,0,0, 1,6,32'h62,       1,32'h0,  0));
    tbl.push_back(v(0,0,0,           0,0,0,           0,0, 0,0,0, 1,10,32'hA0,      0,32'h0,  1));
    tbl.push_back(v(0,0,0,           0,0,0,           0,0, 0,0,0, 1,11,32'hB0,      0,32'h0,  1));
    tbl.push_back(v(0,0,0,           0,0,0,           0,0, 0,0,0, 0,11,32'hB0,      0,32'h0,  1));
    tbl.push_back(v(0,0,0,           1,7,32'h77,      1,7, 0,0,0, 0,11,32'hB0,      0,32'h80, 1));
    tbl.push_back(v(0,0,0,           0,0,0,           1,7, 0,0,0, 1,7,32'h77,       0,32'h80, 1));
    tbl.push_back(v(0,0,0,           0,0,0,           0,0, 0,0,0, 0,7,32'h77,       0,32'h80, 1));
    tbl.push_back(v(0,0,0,           1,0,32'h99,      0,0, 0,0,0, 0,7,32'h77,       0,32'h80, 1));
    tbl.push_back(v(0,0,0,           0,0,0,           0,0, 0,0,0, 0,7,32'h77,       0,32'h80, 1));
    tbl.push_back(v(0,0,0,           0,0,0,           0,0, 0,0,7, 0,7,32'h77,       1,32'h80, 1));
    tbl.push_back(v(0,0,0,           0,0,0,           0,0, 0,7,0, 0,7,32'h77,       1,32'h80, 1));
    tbl.push_back(v(0,0,0,           0,0,0,           0,0, 0,0,0, 0,7,32'h77,       0,32'h80, 1));

    // Reset state, held across a posedge.
    repeat (2) @(negedge clk);
    chk("rst_WE3", {31'd0, bus.WE3}, 32'd0);
    chk("rst_A3", {27'd0, bus.A3}, 32'd0);
    chk("rst_WD3", bus.WD3, 32'd0);
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    chk("rst_pending", bus.pending, 32'd0);
    chk("rst_lu_ready", {31'd0, bus.lu_ready}, 32'd0);
    reset = 1;
    #1 chk("rel_lu_ready_low", {31'd0, bus.lu_ready}, 32'd0);
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      bus.wb_we = tbl[i].wb_we; bus.wb_addr = tbl[i].wb_addr; bus.wb_data = tbl[i].wb_data;
      bus.lu_valid = tbl[i].lu_valid; bus.lu_addr = tbl[i].lu_addr; bus.lu_data = tbl[i].lu_data;
      bus.issue_valid = tbl[i].iv; bus.issue_dst = tbl[i].idst;
      bus.rs_addr = tbl[i].rs; bus.rt_addr = tbl[i].rt; bus.rd_addr = tbl[i].rd;
      step();
      chk($sformatf("v%0d_WE3", i), {31'd0, bus.WE3}, {31'd0, tbl[i].e_we});
      chk($sformatf("v%0d_A3", i), {27'd0, bus.A3}, {27'd0, tbl[i].e_a3});
      chk($sformatf("v%0d_WD3", i), bus.WD3, tbl[i].e_wd3);
      chk($sformatf("v%0d_stall", i), {31'd0, bus.stall}, {31'd0, tbl[i].e_stall});
      chk($sformatf("v%0d_pending", i), bus.pending, tbl[i].e_pend);
      chk($sformatf("v%0d_lu_ready", i), {31'd0, bus.lu_ready}, {31'd0, tbl[i].e_rdy});
    end

    // Async reset with one FIFO entry and pending[8] set.
    idle_inputs();
    do_reset();
    bus.wb_we = 1; bus.wb_addr = 1; bus.wb_data = 32'h1;
    step();
    bus.wb_addr = 1; bus.wb_data = 32'h2;
    bus.lu_valid = 1; bus.lu_addr = 2; bus.lu_data = 32'h22;
    bus.issue_valid = 1; bus.issue_dst = 8;
    step();
    chk("pre_rst_pending", bus.pending, 32'h100);
    chk("pre_rst_WE3", {31'd0, bus.WE3}, 32'd1);
    idle_inputs();
    #2 reset = 0;
    #1;
    chk("arst_WE3", {31'd0, bus.WE3}, 32'd0);
    chk("arst_A3", {27'd0, bus.A3}, 32'd0);
    chk("arst_WD3", bus.WD3, 32'd0);
    chk("arst_pending", bus.pending, 32'd0);
    chk("arst_lu_ready", {31'd0, bus.lu_ready}, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1;
    step();
    chk("post_rst_lu_ready", {31'd0, bus.lu_ready}, 32'd1);
    chk("post_rst_WE3", {31'd0, bus.WE3}, 32'd0);
    step();
    chk("post_rst_fifo_empty", {31'd0, bus.WE3}, 32'd0);

    // Random traffic against the model; heavy writeback first to exercise starvation and full FIFO.
    chk_model = 1;
    for (int i = 0; i < 800; i++) begin
      if (i == 400) do_reset();
      bus.wb_we       = ($urandom_range(0, 9) < ((i < 400) ? 8 : 4));
      bus.wb_addr     = 5'($urandom_range(0, 7));
      bus.wb_data     = $urandom;
      bus.lu_valid    = ($urandom_range(0, 9) < 4);
      bus.lu_addr     = 5'($urandom_range(0, 7));
      bus.lu_data     = $urandom;
      bus.issue_valid = ($urandom_range(0, 9) < 3);
      bus.issue_dst   = 5'($urandom_range(0, 7));
      bus.rs_addr     = 5'($urandom_range(0, 7));
      bus.rt_addr     = 5'($urandom_range(0, 7));
      bus.rd_addr     = 5'($urandom_range(0, 7));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
